// File: rtl/mcq_pkg.sv
// rtl/mcq_pkg.sv - shared types and width helpers for multi_channel_queue
//
// Purpose: width helpers and the per-queue pointer pair type used by the
// multi-channel queue. Pointers are held in a fixed 32-bit container and are
// masked to CNT_BITS by the user. The constant upper bits optimise away.
package mcq_pkg;

  localparam int PTR_BITS_MAX = 32;

  // $clog2 with a floor of 1, so a single-queue build still has a 1-bit qid.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int qid_bits(input int num_queues);
    return clog2_min1(num_queues);
  endfunction

  // One extra bit over the address so that full and empty are distinguishable.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [PTR_BITS_MAX-1:0] ptr_t;

  typedef struct packed {
    ptr_t wr;
    ptr_t rd;
  } ptr_pair_t;

endpackage

// File: rtl/mcq_sdp_ram.sv
// rtl/mcq_sdp_ram.sv - simple dual-port RAM, one write port, one synchronous read port
//
// Purpose: backing store shared by all logical queues. It has no reset. The read
// register updates only when re_i is high, so between reads it holds its last word.
// Ports:
//   clk_i              clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i       read request and address
//   rdata_o            registered read data
module mcq_sdp_ram #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_TOTAL = 256,
  parameter int AW          = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH_TOTAL];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_channel_queue.sv
// rtl/multi_channel_queue.sv - NUM_QUEUES logical FIFOs statically partitioned in one shared RAM
//
// Purpose: a full-rate multi-queue FIFO. Each queue can enqueue and dequeue every
// cycle, on independent queue selects, and has its own status outputs.
// Optional feature: define MULTI_CHANNEL_QUEUE_DROP_CNT_EN to add drop_cnt_o.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   enq_data_i/enq_qid_i/enq_valid_i, enq_ready_o    enqueue side
//   deq_qid_i/deq_valid_i, deq_ready_o               dequeue side
//   data_o/data_valid_o/data_qid_o                   dequeued word, 1-cycle latency
//   empty_o/full_o/fill_o                            per-queue status
//   drop_cnt_o                  saturating count of rejected enqueues (optional)
module multi_channel_queue
  import mcq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int NUM_QUEUES = 4,
  localparam int ADDR_BITS = $clog2(DEPTH),
  localparam int QID_BITS  = qid_bits(NUM_QUEUES),
  localparam int CNT_BITS  = cnt_bits(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [WIDTH-1:0]               enq_data_i,
  input  logic [QID_BITS-1:0]            enq_qid_i,
  input  logic                           enq_valid_i,
  output logic                           enq_ready_o,
  input  logic [QID_BITS-1:0]            deq_qid_i,
  input  logic                           deq_valid_i,
  output logic                           deq_ready_o,
  output logic [WIDTH-1:0]               data_o,
  output logic                           data_valid_o,
  output logic [QID_BITS-1:0]            data_qid_o,
  output logic [NUM_QUEUES-1:0]          empty_o,
  output logic [NUM_QUEUES-1:0]          full_o,
  output logic [NUM_QUEUES*CNT_BITS-1:0] fill_o
`ifdef MULTI_CHANNEL_QUEUE_DROP_CNT_EN
  ,
  output logic [31:0]                    drop_cnt_o
`endif
);

  // Status vectors are padded to a power of two so that any qid value indexes
  // safely. The padding slots report full and empty, so they never accept.
  localparam int   QN       = 1 << QID_BITS;
  localparam int   AW       = QID_BITS + ADDR_BITS;
  localparam ptr_t CNT_MASK = ptr_t'((64'd1 << CNT_BITS) - 64'd1);
  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);

  logic [QN-1:0]                 full_ext;
  logic [QN-1:0]                 empty_ext;
  logic [QN-1:0][ADDR_BITS-1:0]  wr_lo;
  logic [QN-1:0][ADDR_BITS-1:0]  rd_lo;

  logic                 enq_acc;
  logic                 deq_acc;
  logic [WIDTH-1:0]     ram_rdata;
  logic                 data_valid_q;
  logic [QID_BITS-1:0]  data_qid_q;
  logic                 rd_seen_q;

  assign enq_ready_o = !full_ext[enq_qid_i];
  assign deq_ready_o = !empty_ext[deq_qid_i];

  // An accept in the reset cycle is discarded, so it must not touch the RAM either.
  assign enq_acc = !rst_i && enq_valid_i && enq_ready_o;
  assign deq_acc = !rst_i && deq_valid_i && deq_ready_o;

  generate
    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
      ptr_pair_t ptr_q;
      ptr_pair_t ptr_d;
      ptr_t      fill_w;
      logic      enq_hit;
      logic      deq_hit;

      assign enq_hit = enq_acc && (enq_qid_i == QID_BITS'(q));
      assign deq_hit = deq_acc && (deq_qid_i == QID_BITS'(q));

      always_comb begin
        ptr_d = ptr_q;
        if (enq_hit) begin
          ptr_d.wr = (ptr_q.wr + ptr_t'(1)) & CNT_MASK;
        end
        if (deq_hit) begin
          ptr_d.rd = (ptr_q.rd + ptr_t'(1)) & CNT_MASK;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end

      // Modular difference stays correct across the binary pointer wrap.
      assign fill_w       = (ptr_q.wr - ptr_q.rd) & CNT_MASK;
      assign empty_ext[q] = (ptr_q.wr == ptr_q.rd);
      assign full_ext[q]  = (fill_w == DEPTH_P);
      assign wr_lo[q]     = ptr_q.wr[ADDR_BITS-1:0];
      assign rd_lo[q]     = ptr_q.rd[ADDR_BITS-1:0];
      assign fill_o[q*CNT_BITS +: CNT_BITS] = fill_w[CNT_BITS-1:0];
    end

    for (genvar q = NUM_QUEUES; q < QN; q++) begin : g_pad
      assign empty_ext[q] = 1'b1;
      assign full_ext[q]  = 1'b1;
      assign wr_lo[q]     = '0;
      assign rd_lo[q]     = '0;
    end
  endgenerate

  assign empty_o = empty_ext[NUM_QUEUES-1:0];
  assign full_o  = full_ext[NUM_QUEUES-1:0];

  mcq_sdp_ram #(
    .WIDTH       (WIDTH),
    .DEPTH_TOTAL (DEPTH * NUM_QUEUES),
    .AW          (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (enq_acc),
    .waddr_i ({enq_qid_i, wr_lo[enq_qid_i]}),
    .wdata_i (enq_data_i),
    .re_i    (deq_acc),
    .raddr_i ({deq_qid_i, rd_lo[deq_qid_i]}),
    .rdata_o (ram_rdata)
  );

  // The RAM read register holds between reads but cannot be reset. rd_seen_q
  // forces data_o to zero from reset until the first read after it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_valid_q <= 1'b0;
      data_qid_q   <= '0;
      rd_seen_q    <= 1'b0;
    end else begin
      data_valid_q <= deq_acc;
      if (deq_acc) begin
        data_qid_q <= deq_qid_i;
        rd_seen_q  <= 1'b1;
      end
    end
  end

  assign data_o       = rd_seen_q ? ram_rdata : '0;
  assign data_valid_o = data_valid_q;
  assign data_qid_o   = data_qid_q;

`ifdef MULTI_CHANNEL_QUEUE_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (enq_valid_i && !enq_ready_o && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multi_channel_queue.sv
// tb/tb_multi_channel_queue.sv - self-checking bench for multi_channel_queue
module tb_multi_channel_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int NQ    = 4;
  localparam int QB    = 2;
  localparam int CB    = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  enq_data;
  logic [QB-1:0]     enq_qid;
  logic              enq_valid;
  logic              enq_ready;
  logic [QB-1:0]     deq_qid;
  logic              deq_valid;
  logic              deq_ready;
  logic [WIDTH-1:0]  data_o;
  logic              data_valid;
  logic [QB-1:0]     data_qid;
  logic [NQ-1:0]     empty_o;
  logic [NQ-1:0]     full_o;
  logic [NQ*CB-1:0]  fill_o;
`ifdef MULTI_CHANNEL_QUEUE_DROP_CNT_EN
  logic [31:0]       drop_cnt;
`endif

  multi_channel_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_QUEUES(NQ)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enq_data_i   (enq_data),
    .enq_qid_i    (enq_qid),
    .enq_valid_i  (enq_valid),
    .enq_ready_o  (enq_ready),
    .deq_qid_i    (deq_qid),
    .deq_valid_i  (deq_valid),
    .deq_ready_o  (deq_ready),
    .data_o       (data_o),
    .data_valid_o (data_valid),
    .data_qid_o   (data_qid),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .fill_o       (fill_o)
`ifdef MULTI_CHANNEL_QUEUE_DROP_CNT_EN
    ,
    .drop_cnt_o   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CB-1:0] fill_of(input int q);
    return fill_o[q*CB +: CB];
  endfunction

  // Reference model: one plain queue of words per logical queue.
  logic [WIDTH-1:0] mq [NQ][$];
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic [QB-1:0]    exp_qid;
  logic [31:0]      exp_drop;
  bit               model_on = 0;

  always @(negedge clk) begin
    if (model_on) begin
      for (int q = 0; q < NQ; q++) begin
        chk("empty", empty_o[q], mq[q].size() == 0);
        chk("full", full_o[q], mq[q].size() == DEPTH);
        chk("fill", fill_o[q*CB +: CB], 64'(mq[q].size()));
      end
      chk("enq_ready", enq_ready, mq[enq_qid].size() < DEPTH);
      chk("deq_ready", deq_ready, mq[deq_qid].size() > 0);
      chk("data_valid", data_valid, exp_valid);
      chk("data", data_o, exp_data);
      chk("data_qid", data_qid, exp_qid);
`ifdef MULTI_CHANNEL_QUEUE_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, exp_drop);
`endif
    end
    if (rst) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
      exp_valid = 0;
      exp_data  = '0;
      exp_qid   = '0;
      exp_drop  = '0;
      model_on  = 1;
    end else if (model_on) begin
      bit enq_ok, deq_ok;
      enq_ok = enq_valid && (mq[enq_qid].size() < DEPTH);
      deq_ok = deq_valid && (mq[deq_qid].size() > 0);
      exp_valid = deq_ok;
      if (deq_ok) begin
        exp_data = mq[deq_qid].pop_front();
        exp_qid  = deq_qid;
      end
      if (enq_ok) mq[enq_qid].push_back(enq_data);
      if (enq_valid && !enq_ok && exp_drop != 32'hFFFF_FFFF) exp_drop++;
    end
  end

  task automatic cyc(input logic ev, input logic [QB-1:0] eq, input logic [WIDTH-1:0] ed,
                     input logic dv, input logic [QB-1:0] dq);
    enq_valid = ev;
    enq_qid   = eq;
    enq_data  = ed;
    deq_valid = dv;
    deq_qid   = dq;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enq_valid = 0; enq_qid = 0; enq_data = 0; deq_valid = 0; deq_qid = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_empty", empty_o, 4'hF);
    chk("rst_full", full_o, 4'h0);
    chk("rst_fill", fill_o, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_o, 0);

    // Two words through q2, back-to-back dequeue.
    cyc(1, 2, 32'hA1, 0, 0);
    chk("t1_fill_a", fill_of(2), 1);
    cyc(1, 2, 32'hA2, 0, 0);
    chk("t1_fill_b", fill_of(2), 2);
    cyc(0, 0, 0, 1, 2);
    chk("t1_valid_a", data_valid, 1);
    chk("t1_data_a", data_o, 32'hA1);
    chk("t1_qid_a", data_qid, 2);
    chk("t1_fill_c", fill_of(2), 1);
    cyc(0, 0, 0, 1, 2);
    chk("t1_data_b", data_o, 32'hA2);
    chk("t1_fill_d", fill_of(2), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_valid_off", data_valid, 0);
    chk("t1_data_hold", data_o, 32'hA2);

    // Fill q0 to DEPTH, then overflow once.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'h100 + i, 0, 0);
    chk("t2_full", full_o[0], 1);
    chk("t2_ready", enq_ready, 0);
    chk("t2_fill", fill_of(0), 64);
    cyc(1, 0, 32'hDEAD, 0, 0);
    chk("t2_fill_after", fill_of(0), 64);
`ifdef MULTI_CHANNEL_QUEUE_DROP_CNT_EN
    chk("t2_drop", drop_cnt, 1);
`endif
    cyc(1, 1, 32'hB0B0_0001, 0, 0);
    chk("t2_q1", fill_of(1), 1);

    // No bypass: enqueue and dequeue of empty q3 in the same cycle.
    enq_valid = 1; enq_qid = 3; enq_data = 32'hC3; deq_valid = 1; deq_qid = 3;
    #1;
    chk("t3_deq_ready", deq_ready, 0);
    @(posedge clk);
    #1;
    chk("t3_no_valid", data_valid, 0);
    chk("t3_fill", fill_of(3), 1);
    cyc(0, 0, 0, 1, 3);
    chk("t3_valid", data_valid, 1);
    chk("t3_data", data_o, 32'hC3);
    chk("t3_qid", data_qid, 3);

    // Top q1 up to full, then 200 cycles of simultaneous enqueue and dequeue.
    for (int i = 1; i < DEPTH; i++) cyc(1, 1, 32'hB0B0_0000 + i + 1, 0, 0);
    chk("t4_full", full_o[1], 1);
    cyc(1, 1, 32'h1000, 1, 1);
    chk("t4_first", data_o, 32'hB0B0_0001);
    chk("t4_fill_first", fill_of(1), 63);
    for (int i = 1; i < 200; i++) cyc(1, 1, 32'h1000 + i, 1, 1);
    chk("t4_fill_end", fill_of(1), 63);

    // Round-robin enqueue, reverse-order dequeue.
    do_reset();
    for (int r = 0; r < 6; r++)
      for (int q = 0; q < NQ; q++) cyc(1, 2'(q), 32'h5000_0000 | (r << 8) | q, 0, 0);
    cyc(0, 0, 0, 1, 3);
    chk("t5_data", data_o, 32'h5000_0003);
    chk("t5_qid", data_qid, 3);
    for (int r = 0; r < 6; r++)
      for (int q = NQ - 1; q >= 0; q--) cyc(0, 0, 0, 1, 2'(q));

    // Randomised traffic: a filling phase then a draining phase.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) != 0, 2'($urandom), $urandom, ($urandom % 3) == 0, 2'($urandom));
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 5) == 0, 2'($urandom), $urandom, ($urandom % 4) != 0, 2'($urandom));

    // Reset mid-stream with traffic present in the reset cycle.
    for (int i = 0; i < 20; i++) cyc(1, 2'(i), $urandom, i > 10, 2'(i));
    rst = 1'b1;
    cyc(1, 0, 32'hEEEE, 1, 1);
    rst = 1'b0;
    chk("t6_empty", empty_o, 4'hF);
    chk("t6_fill", fill_o, 0);
    chk("t6_valid", data_valid, 0);
    chk("t6_data", data_o, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t6_deq_ignored", data_valid, 0);
    chk("t6_fill_after", fill_of(0), 0);
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
